// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler
//   Generates the audio sample-rate tick. On each tick it sweeps the enabled
//   ADC channels in ascending order. For each channel it issues one conversion
//   request, waits for completion (bounded by TIMEOUT) and publishes the result
//   as a one-cycle sample strobe.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   enable                     tick counter runs while high, held at 0 otherwise
//   chan_mask                  channel enables, captured when a sweep starts
//   clear_flags                pulse, clears overrun / timeout_err (a set wins)
//   adc_start, adc_addr        conversion request and channel address to the SPI side
//   adc_done, adc_data         conversion complete strobe and result from the SPI side
//   smp_valid, smp_chan/data   published sample strobe, channel and data
//   sweep_done                 pulse with the last sample of a sweep
//   overrun, timeout_err       sticky error flags
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a tick with a non-empty channel mask
// SELECT  | pick the lowest pending channel at or above ch
// START   | one-cycle conversion request, timeout counter cleared
// WAIT    | waiting for adc_done, aborts the sweep after TIMEOUT cycles
// PUBLISH | sample strobe; next channel or end of sweep

module adc_sample_scheduler #(
  parameter int SAMPLE_DIV = 1000,
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          chan_mask,
  input  logic                       clear_flags,
  output logic                       adc_start,
  output logic [$clog2(NUM_CH)-1:0]  adc_addr,
  input  logic                       adc_done,
  input  logic [DATA_W-1:0]          adc_data,
  output logic                       smp_valid,
  output logic [$clog2(NUM_CH)-1:0]  smp_chan,
  output logic [DATA_W-1:0]          smp_data,
  output logic                       sweep_done,
  output logic                       overrun,
  output logic                       timeout_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
  // The expiry compare fires in the TIMEOUT-th WAIT cycle.
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT, S_PUBLISH
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0]   ch;
  logic [TO_W-1:0]   to_cnt;
  logic              to_expire;
  logic              sweep_go;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_found;
  logic              more_pending;

  assign tick      = enable && (tick_cnt == TICK_LAST);
  assign to_expire = (to_cnt == TO_LAST);
  assign sweep_go  = tick && (chan_mask != '0);
  assign adc_addr  = ch;

  // Lowest pending channel at index >= ch, and whether any pending channel lies above ch.
  always_comb begin
    sel_found    = 1'b0;
    sel_ch       = '0;
    more_pending = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(ch))) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(ch))) begin
        more_pending = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (sweep_go) state_next = S_SELECT;
      S_SELECT:  state_next = sel_found ? S_START : S_IDLE;
      S_START:   state_next = S_WAIT;
      S_WAIT: begin
        if (adc_done)       state_next = S_PUBLISH;
        else if (to_expire) state_next = S_IDLE;
      end
      S_PUBLISH: state_next = more_pending ? S_SELECT : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    adc_start  = (state == S_START);
    smp_valid  = (state == S_PUBLISH);
    sweep_done = (state == S_PUBLISH) && !more_pending;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      mask_q      <= '0;
      ch          <= '0;
      to_cnt      <= '0;
      smp_chan    <= '0;
      smp_data    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (!enable || tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (sweep_go) begin
            mask_q <= chan_mask;
            ch     <= '0;
          end
        end
        S_SELECT: begin
          if (sel_found) ch <= sel_ch;
        end
        S_START: begin
          to_cnt <= '0;
        end
        S_WAIT: begin
          if (adc_done) begin
            smp_data <= adc_data;
            smp_chan <= ch;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_PUBLISH: begin
          mask_q[ch] <= 1'b0;
          if (more_pending) ch <= ch + 1'b1;
        end
        default: ;
      endcase

      // Sticky flags: a set in the same cycle as clear_flags wins.
      if (tick && (state != S_IDLE)) overrun <= 1'b1;
      else if (clear_flags)          overrun <= 1'b0;

      if ((state == S_WAIT) && !adc_done && to_expire) timeout_err <= 1'b1;
      else if (clear_flags)                            timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Testbench for adc_sample_scheduler (SAMPLE_DIV=40, NUM_CH=8, TIMEOUT=16).
// A behavioural ADC answers each adc_start after a programmable number of
// cycles with data 12'hA00 | addr; a monitor tallies strobes per scenario.
module tb_adc_sample_scheduler;

  localparam int SDIV = 40;
  localparam int TOUT = 16;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  chan_mask;
  logic        clear_flags;
  logic        adc_start;
  logic [2:0]  adc_addr;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        smp_valid;
  logic [2:0]  smp_chan;
  logic [11:0] smp_data;
  logic        sweep_done;
  logic        overrun;
  logic        timeout_err;

  adc_sample_scheduler #(
    .SAMPLE_DIV (SDIV),
    .NUM_CH     (8),
    .DATA_W     (12),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .chan_mask   (chan_mask),
    .clear_flags (clear_flags),
    .adc_start   (adc_start),
    .adc_addr    (adc_addr),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .smp_valid   (smp_valid),
    .smp_chan    (smp_chan),
    .smp_data    (smp_data),
    .sweep_done  (sweep_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rel     = 0;
  int model_delay = 0;
  int pulse_cyc   = -1;

  // monitor tallies, cleared whenever rel moves
  int          seen_rel = -1;
  int          n_start, n_valid, n_sweep, first_start, n_bad;
  logic [2:0]  last_addr, last_chan;
  logic [11:0] last_data;

  int          m_cnt;
  logic [2:0]  m_addr;

  typedef struct {
    logic [7:0]  mask;
    int          delay;   // ADC answer latency, 0 = never answers
    int          dis_at;  // cycle offset where enable drops, 0 = never
    int          en_at;   // cycle offset where enable returns, 0 = never
    int          run;
    int          starts;
    int          valids;
    int          sweeps;
    logic        ov;
    logic        to;
    logic [2:0]  chan;
    logic [11:0] data;
    logic [2:0]  addr;
    int          first;
  } row_t;

  row_t rows [0:9];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ADC model
  initial begin
    m_cnt    = 0;
    m_addr   = '0;
    adc_done = 1'b0;
    adc_data = 12'h5A5;
    forever begin
      @(posedge clk); #2;
      adc_done = 1'b0;
      adc_data = 12'h5A5;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          adc_done = 1'b1;
          adc_data = 12'hA00 | {9'd0, m_addr};
        end
      end
      if (adc_start && model_delay > 0) begin
        m_cnt  = model_delay;
        m_addr = adc_addr;
      end
      if (cyc == pulse_cyc) begin
        adc_done = 1'b1;
        adc_data = 12'hBEE;
      end
    end
  end

  // monitor
  initial begin
    n_bad = 0;
    forever begin
      @(negedge clk);
      if (rel != seen_rel) begin
        seen_rel    = rel;
        n_start     = 0;
        n_valid     = 0;
        n_sweep     = 0;
        first_start = 0;
        last_addr   = '0;
        last_chan   = '0;
        last_data   = '0;
      end
      if (adc_start) begin
        if (n_start == 0) first_start = cyc - rel;
        n_start++;
        last_addr = adc_addr;
      end
      if (smp_valid) begin
        n_valid++;
        last_chan = smp_chan;
        last_data = smp_data;
        if (smp_data != (12'hA00 | {9'd0, smp_chan})) n_bad++;
      end
      if (sweep_done) begin
        n_sweep++;
        if (!smp_valid) n_bad++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] mask, input int delay);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable      = 1'($urandom);
      chan_mask   = 8'($urandom);
      clear_flags = 1'($urandom);
      @(posedge clk); #1;
    end
    check("reset_outputs",
          {adc_start, adc_addr, smp_valid, smp_chan, smp_data, sweep_done, overrun, timeout_err},
          32'd0);
    reset       = 1'b0;
    enable      = 1'b1;
    chan_mask   = mask;
    clear_flags = 1'b0;
    model_delay = delay;
    rel         = cyc;
  endtask

  task automatic run_row(input int idx, input row_t r);
    do_reset(r.mask, r.delay);
    for (int c = 1; c <= r.run; c++) begin
      @(posedge clk); #1;
      if (r.dis_at != 0 && c == r.dis_at) enable = 1'b0;
      if (r.en_at != 0 && c == r.en_at)   enable = 1'b1;
    end
    @(negedge clk); #1;
    check($sformatf("row%0d_starts", idx),      n_start,     r.starts);
    check($sformatf("row%0d_valids", idx),      n_valid,     r.valids);
    check($sformatf("row%0d_sweeps", idx),      n_sweep,     r.sweeps);
    check($sformatf("row%0d_overrun", idx),     overrun,     r.ov);
    check($sformatf("row%0d_timeout", idx),     timeout_err, r.to);
    check($sformatf("row%0d_last_chan", idx),   last_chan,   r.chan);
    check($sformatf("row%0d_last_data", idx),   last_data,   r.data);
    check($sformatf("row%0d_last_addr", idx),   last_addr,   r.addr);
    check($sformatf("row%0d_first_start", idx), first_start, r.first);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; chan_mask = '0; clear_flags = 1'b0;

    // tick at offset 39, first adc_start at 41; per channel: start S, done S+5, valid S+6, next start S+8
    //             mask   dly dis en  run  st vl sw ov    to    chan  data     addr  first
    rows[0] = '{8'h05,  5,  0,  0, 100, 4, 4, 2, 1'b0, 1'b0, 3'd2, 12'hA02, 3'd2, 41};
    rows[1] = '{8'h80,  5,  0,  0, 100, 2, 2, 2, 1'b0, 1'b0, 3'd7, 12'hA07, 3'd7, 41};
    rows[2] = '{8'h00,  5,  0,  0, 205, 0, 0, 0, 1'b0, 1'b0, 3'd0, 12'h000, 3'd0, 0};
    rows[3] = '{8'hFF,  5,  0,  0, 110, 8, 8, 1, 1'b1, 1'b0, 3'd7, 12'hA07, 3'd7, 41};
    rows[4] = '{8'h03,  0,  0,  0,  85, 2, 0, 0, 1'b0, 1'b1, 3'd0, 12'h000, 3'd0, 41};
    rows[5] = '{8'h01, 16,  0,  0, 100, 2, 2, 2, 1'b0, 1'b0, 3'd0, 12'hA00, 3'd0, 41};
    rows[6] = '{8'h01, 17,  0,  0, 100, 2, 0, 0, 1'b0, 1'b1, 3'd0, 12'h000, 3'd0, 41};
    rows[7] = '{8'hFF,  5, 60,  0, 200, 8, 8, 1, 1'b0, 1'b0, 3'd7, 12'hA07, 3'd7, 41};
    rows[8] = '{8'h01,  5, 20, 70, 130, 1, 1, 1, 1'b0, 1'b0, 3'd0, 12'hA00, 3'd0, 111};
    rows[9] = '{8'h92,  5,  0,  0,  75, 3, 3, 1, 1'b0, 1'b0, 3'd7, 12'hA07, 3'd7, 41};

    for (int i = 0; i < 10; i++) run_row(i, rows[i]);

    // overrun: set at the busy tick (offset 79) even with clear_flags in that cycle,
    // cleared by a later pulse; mask change mid-sweep has no effect
    do_reset(8'hFF, 5);
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1;
      if (c == 50) chan_mask = 8'h00;
      clear_flags = (c == 79 || c == 90);
      if (c == 79 || c == 80 || c == 91) begin
        @(negedge clk);
        check($sformatf("ovr_c%0d", c), overrun, (c == 80));
      end
    end
    @(negedge clk);
    check("ovr_sweep_valids", n_valid, 8);
    check("ovr_sweep_done",   n_sweep, 1);

    // timeout: 16 WAIT cycles (42..57), flag visible at 58 despite clear at 57
    do_reset(8'h03, 0);
    for (int c = 1; c <= 62; c++) begin
      @(posedge clk); #1;
      clear_flags = (c == 57 || c == 60);
      if (c == 57 || c == 58 || c == 61) begin
        @(negedge clk);
        check($sformatf("tout_c%0d", c), timeout_err, (c == 58));
      end
    end
    @(negedge clk);
    check("tout_starts", n_start, 1);
    check("tout_valids", n_valid, 0);

    // reset in WAIT, then a late adc_done two cycles after release
    do_reset(8'h01, 0);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 45) reset = 1'b1;
      if (c == 46) begin
        @(negedge clk);
        check("midreset_outputs",
              {adc_start, adc_addr, smp_valid, smp_chan, smp_data, sweep_done, overrun, timeout_err},
              32'd0);
      end
      if (c == 47) begin
        reset = 1'b0;
        rel   = cyc;
      end
      if (c == 49) pulse_cyc = cyc;
    end
    @(negedge clk);
    check("midreset_valids",  n_valid,     0);
    check("midreset_data",    smp_data,    12'h000);
    check("midreset_overrun", overrun,     1'b0);
    check("midreset_timeout", timeout_err, 1'b0);
    check("midreset_starts",  n_start,     1);
    check("midreset_first",   first_start, 41);

    check("protocol_errors", n_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
